gf256_mul_arbiter: RTL

GF256_MUL_ARBITER -- requirements
Module: gf256_mul_arbiter

---
 rtl/gf256_pkg.sv | 34 +++
 rtl/gf256_mul.sv | 14 +
 rtl/gf256_mul_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/gf256_pkg.sv
// Shared GF(2^8) types and constants for the multiplier arbiter.
// gf_mul is the reference shift-and-reduce product used by gf256_mul.
package gf256_pkg;

    localparam int         GF_W         = 8;
    localparam logic [8:0] POLY_DEFAULT = 9'h11D;
    localparam int         ID_W_MAX     = 3;

    typedef logic [GF_W-1:0] gf_t;

    typedef struct packed {
        gf_t a;
        gf_t b;
    } req_t;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        gf_t                 data;
    } rsp_t;

    // poly_lo is the polynomial without its x^8 term, which is implicit in the reduction
    function automatic gf_t gf_mul(input gf_t a, input gf_t b, input gf_t poly_lo);
        gf_t acc;
        gf_t x;
        acc = '0;
        x   = a;
        for (int i = 0; i < GF_W; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[GF_W-1] ? ((x << 1) ^ poly_lo) : (x << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf256_mul.sv
// Purely combinational GF(2^8) multiplier: poly_out = poly_a * poly_b mod POLY.
module gf256_mul
    import gf256_pkg::*;
#(
    parameter logic [8:0] POLY = POLY_DEFAULT
) (
    input  logic [GF_W-1:0] poly_a,
    input  logic [GF_W-1:0] poly_b,
    output logic [GF_W-1:0] poly_out
);

    assign poly_out = gf_mul(poly_a, poly_b, POLY[GF_W-1:0]);

endmodule

// File: rtl/gf256_mul_arbiter.sv
// Round-robin arbiter sharing one GF(2^8) multiplier among NUM_REQ requesters.
// Define GF256_MUL_ARB_PIPE_EN to add a register stage after the multiplier (latency 2).
module gf256_mul_arbiter
    import gf256_pkg::*;
#(
    parameter int         NUM_REQ = 4,
    parameter logic [8:0] POLY    = POLY_DEFAULT,
    localparam int        ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [GF_W*NUM_REQ-1:0] req_a,
    input  logic [GF_W*NUM_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [GF_W-1:0]         rsp_data,
    output logic                    busy
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    int              cand_i;
    logic            accept_en;
    logic            accept;
    req_t            sel;
    gf_t             prod;

    // Search upward from ptr with wrap; first valid requester wins
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_i      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_i = int'(ptr_q) + k;
            if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
            if (!grant_found && req_valid[cand_i[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_i[ID_W-1:0];
            end
        end
    end

    assign accept = !reset && accept_en && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
        sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel.a = req_a[k*GF_W +: GF_W];
                sel.b = req_b[k*GF_W +: GF_W];
            end
        end
        ptr_d = ptr_q;
        if (accept) ptr_d = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end

    gf256_mul #(.POLY(POLY)) u_mul (
        .poly_a  (sel.a),
        .poly_b  (sel.b),
        .poly_out(prod)
    );

`ifdef GF256_MUL_ARB_PIPE_EN
    logic            vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic [ID_W-1:0] id_p1_q, id_p1_d, id_p2_q, id_p2_d;
    gf_t             data_p1_q, data_p1_d, data_p2_q, data_p2_d;
    logic            adv_p1, adv_p2;

    // New work only enters while the output is free to move, so a stalled output blocks all grants
    always_comb begin
        adv_p2    = !vld_p2_q || rsp_ready;
        adv_p1    = !vld_p1_q || adv_p2;
        accept_en = adv_p2;
        vld_p2_d  = vld_p2_q;
        id_p2_d   = id_p2_q;
        data_p2_d = data_p2_q;
        vld_p1_d  = vld_p1_q;
        id_p1_d   = id_p1_q;
        data_p1_d = data_p1_q;
        if (adv_p2) begin
            vld_p2_d  = vld_p1_q;
            id_p2_d   = id_p1_q;
            data_p2_d = data_p1_q;
        end
        if (adv_p1) begin
            vld_p1_d = accept;
            if (accept) begin
                id_p1_d   = grant_idx;
                data_p1_d = prod;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            vld_p1_q  <= 1'b0;
            id_p1_q   <= '0;
            data_p1_q <= '0;
            vld_p2_q  <= 1'b0;
            id_p2_q   <= '0;
            data_p2_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            vld_p1_q  <= vld_p1_d;
            id_p1_q   <= id_p1_d;
            data_p1_q <= data_p1_d;
            vld_p2_q  <= vld_p2_d;
            id_p2_q   <= id_p2_d;
            data_p2_q <= data_p2_d;
        end
    end

    assign rsp_valid = vld_p2_q;
    assign rsp_id    = id_p2_q;
    assign rsp_data  = data_p2_q;
    assign busy      = vld_p1_q | vld_p2_q;
`else
    logic            vld_p1_q, vld_p1_d;
    logic [ID_W-1:0] id_p1_q, id_p1_d;
    gf_t             data_p1_q, data_p1_d;

    always_comb begin
        accept_en = !vld_p1_q || rsp_ready;
        vld_p1_d  = vld_p1_q;
        id_p1_d   = id_p1_q;
        data_p1_d = data_p1_q;
        if (accept_en) begin
            vld_p1_d = accept;
            if (accept) begin
                id_p1_d   = grant_idx;
                data_p1_d = prod;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q     <= '0;
            vld_p1_q  <= 1'b0;
            id_p1_q   <= '0;
            data_p1_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            vld_p1_q  <= vld_p1_d;
            id_p1_q   <= id_p1_d;
            data_p1_q <= data_p1_d;
        end
    end

    assign rsp_valid = vld_p1_q;
    assign rsp_id    = id_p1_q;
    assign rsp_data  = data_p1_q;
    assign busy      = vld_p1_q;
`endif

endmodule
